mmio_port_responder: RTL and testbench
======================================

// Module: mmio_port_responder
// PURPOSE
//  Memory-mapped I/O responder on the processor's data-memory bus (Address/WriteData/MemRead/MemWrite).
//  Decodes a 16-byte window at BASE_ADDR, owns the PortOut register, synchronizes PortIn, latches input-change
//  events in a sticky status register and counts them. Sits beside DataMemory; Hit steers the load-data mux
//  between RAM and this block. Single-cycle core: reads are combinational, writes commit on the rising clk edge.
// PARAMETERS
//  BASE_ADDR  32'hFFFF_0000  byte base of the register window; bits [3:0] must be 0
//  IN_WIDTH   8              width of PortIn
//  CNT_WIDTH  16             width of the saturating event counter (<=32)
// PORTS
//  clk        in   1          rising-edge clock
//  reset      in   1          asynchronous, active-low reset
//  Address    in   32         byte address from the ALU result
//  WriteData  in   32         store data (rt)
//  MemRead    in   1          load strobe
//  MemWrite   in   1          store strobe
//  PortIn     in   IN_WIDTH   asynchronous external input pins
//  ReadData   out  32         load data; valid in the same cycle as MemRead
//  Hit        out  1          Address is inside the window (combinational)
//  PortOut    out  32         registered output port
//  ChangeIrq  out  1          copy of STATUS.CHG
// BEHAVIOUR
//  Decode: Hit = (Address[31:4] == BASE_ADDR[31:4]); reg = Address[3:2]; Address[1:0] ignored (word access only).
//  Register map (byte offset):
//   0x0 PORT_OUT  RW  32-bit; a store writes PortOut on the next edge
//   0x4 PORT_IN   RO  {zero-fill, in_sync2}; stores ignored
//   0x8 STATUS    R/W1C bit0 CHG (input changed), bit1 OVF (change while CHG already 1); bits[31:2] read 0
//   0xC EVT_CNT   RO, a store of any value clears it; zero-extended to 32 bits
//  Reads: ReadData = selected reg when Hit && MemRead, else 32'h0. Combinational; no wait states.
//  Writes: only when Hit && MemWrite. Load and store in one cycle: ReadData shows the pre-edge value.
//  Synchronizer: in_sync1 <= PortIn; in_sync2 <= in_sync1; in_prev <= in_sync2 (every cycle).
//  Change event chg_evt = (in_sync2 != in_prev), combinational.
//  Latency: PortIn stable before edge N -> PORT_IN reads new value after edge N+1; CHG=1 after edge N+2.
//  CHG: set by chg_evt; cleared by a STATUS store with WriteData[0]=1. Same-cycle set and clear -> set wins (CHG=1).
//  OVF: set when chg_evt && CHG==1 && CHG not being cleared this cycle; cleared by STATUS store with WriteData[1]=1;
//   same-cycle set and clear -> set wins.
//  EVT_CNT: +1 per chg_evt, saturates at all-ones (no wrap). Clear-store and chg_evt same cycle -> count = 1.
//  Pulses shorter than 2 clk periods may be missed or merged; one event per cycle maximum, regardless of bit count.
//  Reset (reset=0, async): PortOut=0, in_sync1/in_sync2/in_prev=0, STATUS=0, EVT_CNT=0, ChangeIrq=0.
//   ReadData/Hit stay combinational during reset (ReadData shows reset values).
//  Reset release with PortIn != 0 yields one legitimate change event (in_prev resets to 0).
//  Reset asserted mid-operation: all state clears immediately; pending store is dropped.
//  Addresses outside the window: no state change, ReadData=0, Hit=0.
// TESTING
//  1 Reset, store 0xDEADBEEF to BASE+0x0 -> PortOut=0xDEADBEEF after edge; load BASE+0x0 -> ReadData=0xDEADBEEF.
//  2 PortIn 0x00->0x5A before edge N -> PORT_IN=0x0000005A after N+1; CHG=1, ChangeIrq=1, EVT_CNT=1 after N+2.
//  3 Two changes with CHG set -> STATUS=0x3; store 0x1 to 0x8 -> STATUS=0x2; store 0x2 -> STATUS=0x0.
//  4 Change event in same cycle as W1C of CHG -> STATUS.CHG stays 1; same cycle as EVT_CNT clear -> EVT_CNT=1.
//  5 CNT_WIDTH=4, 20 changes -> EVT_CNT=0xF (saturated); store to 0xC -> 0x0.
//  6 Store to BASE+0x10 and BASE-0x4 -> Hit=0, no register changes; assert reset mid-run -> all regs 0 at once.

Source files
------------

// File: rtl/mmio_port_responder.sv
// mmio_port_responder
//   Memory-mapped I/O responder on the data-memory bus. It decodes a 16-byte
//   window at BASE_ADDR. It owns the PortOut register and synchronizes PortIn.
//   Input-change events are latched in a sticky status register and counted
//   by a saturating counter. Reads are combinational. Writes commit on the
//   rising clock edge.
//
//   Register map (byte offset, word access only):
//     0x0 PORT_OUT  RW
//     0x4 PORT_IN   RO     {zero-fill, synchronized PortIn}
//     0x8 STATUS    R/W1C  bit0 CHG, bit1 OVF
//     0xC EVT_CNT   RO     any store clears it
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   Address    byte address (bits [1:0] ignored)
//   WriteData  store data
//   MemRead    load strobe
//   MemWrite   store strobe
//   PortIn     asynchronous external input pins
//   ReadData   load data, 0 unless Hit && MemRead
//   Hit        Address falls inside the window
//   PortOut    registered output port
//   ChangeIrq  copy of STATUS.CHG
module mmio_port_responder #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         Address,
  input  logic [31:0]         WriteData,
  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [31:0]         ReadData,
  output logic                Hit,
  output logic [31:0]         PortOut,
  output logic                ChangeIrq
);

  localparam logic [1:0] REG_PORT_OUT = 2'd0;
  localparam logic [1:0] REG_PORT_IN  = 2'd1;
  localparam logic [1:0] REG_STATUS   = 2'd2;
  localparam logic [1:0] REG_EVT_CNT  = 2'd3;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] satInc(input logic [CNT_WIDTH-1:0] v);
    if (v == {CNT_WIDTH{1'b1}}) begin
      return v;
    end
    return v + CNT_WIDTH'(1);
  endfunction

  logic [IN_WIDTH-1:0]  inSync_p1;
  logic [IN_WIDTH-1:0]  inSync_p2;
  logic [IN_WIDTH-1:0]  inPrev_p3;
  logic                 chgFlag;
  logic                 ovfFlag;
  logic [CNT_WIDTH-1:0] evtCnt;

  logic [1:0]           regSel;
  logic                 wrEn;
  logic                 wrPortOut;
  logic                 wrStatus;
  logic                 wrEvtCnt;
  logic                 chgEvt;
  logic                 chgClr;
  logic                 ovfClr;
  logic                 ovfSet;
  logic                 chgNext;
  logic                 ovfNext;
  logic [CNT_WIDTH-1:0] cntNext;

  // Byte lanes are not decoded; only whole-word accesses are supported.
  logic                 unusedAddrLo;
  assign unusedAddrLo = ^Address[1:0];

  assign Hit       = (Address[31:4] == BASE_ADDR[31:4]);
  assign regSel    = Address[3:2];
  assign wrEn      = Hit && MemWrite;
  assign wrPortOut = wrEn && (regSel == REG_PORT_OUT);
  assign wrStatus  = wrEn && (regSel == REG_STATUS);
  assign wrEvtCnt  = wrEn && (regSel == REG_EVT_CNT);

  // At most one event per cycle, however many bits flipped.
  assign chgEvt = (inSync_p2 != inPrev_p3);
  assign chgClr = wrStatus && WriteData[0];
  assign ovfClr = wrStatus && WriteData[1];
  // A change landing on a CHG that is being cleared is not an overflow:
  // software has just consumed the previous event.
  assign ovfSet = chgEvt && chgFlag && !chgClr;

  // Hardware set wins over a same-cycle software clear for both flags.
  always_comb begin
    chgNext = chgFlag;
    if (chgEvt) begin
      chgNext = 1'b1;
    end else if (chgClr) begin
      chgNext = 1'b0;
    end

    ovfNext = ovfFlag;
    if (ovfSet) begin
      ovfNext = 1'b1;
    end else if (ovfClr) begin
      ovfNext = 1'b0;
    end

    // A clear that coincides with an event leaves that event counted.
    cntNext = evtCnt;
    if (wrEvtCnt) begin
      cntNext = chgEvt ? CNT_WIDTH'(1) : '0;
    end else if (chgEvt) begin
      cntNext = satInc(evtCnt);
    end
  end

  always_comb begin
    ReadData = 32'h0;
    if (Hit && MemRead) begin
      case (regSel)
        REG_PORT_OUT: ReadData = PortOut;
        REG_PORT_IN:  ReadData = 32'(inSync_p2);
        REG_STATUS:   ReadData = {30'h0, ovfFlag, chgFlag};
        REG_EVT_CNT:  ReadData = 32'(evtCnt);
        default:      ReadData = 32'h0;
      endcase
    end
  end

  assign ChangeIrq = chgFlag;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inSync_p1 <= '0;
      inSync_p2 <= '0;
      inPrev_p3 <= '0;
      PortOut   <= 32'h0;
      chgFlag   <= 1'b0;
      ovfFlag   <= 1'b0;
      evtCnt    <= '0;
    end else begin
      // Stage 1/2: two-flop synchronizer on the asynchronous pins
      inSync_p1 <= PortIn;
      inSync_p2 <= inSync_p1;
      // Stage 3: previous synchronized sample for edge detection
      inPrev_p3 <= inSync_p2;
      if (wrPortOut) begin
        PortOut <= WriteData;
      end
      chgFlag <= chgNext;
      ovfFlag <= ovfNext;
      evtCnt  <= cntNext;
    end
  end

endmodule

// File: tb/tb_mmio_port_responder.sv
// Directed bench for mmio_port_responder. Two instances share every input:
// the default configuration and a CNT_WIDTH=4 copy that exercises counter
// saturation. Inputs change 1 ns after the rising edge, and outputs are
// sampled in the same low-activity window.
module tb_mmio_port_responder;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam logic [31:0] A_OUT = BASE + 32'h0;
  localparam logic [31:0] A_IN  = BASE + 32'h4;
  localparam logic [31:0] A_ST  = BASE + 32'h8;
  localparam logic [31:0] A_CNT = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [7:0]  PortIn;
  logic [31:0] ReadData,  ReadDataS;
  logic        Hit,       HitS;
  logic [31:0] PortOut,   PortOutS;
  logic        ChangeIrq, ChangeIrqS;

  int nTests = 0;
  int nFail  = 0;

  mmio_port_responder #(.BASE_ADDR(BASE), .IN_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .PortIn(PortIn),
    .ReadData(ReadData), .Hit(Hit), .PortOut(PortOut), .ChangeIrq(ChangeIrq)
  );

  mmio_port_responder #(.BASE_ADDR(BASE), .IN_WIDTH(8), .CNT_WIDTH(4)) dutS (
    .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .PortIn(PortIn),
    .ReadData(ReadDataS), .Hit(HitS), .PortOut(PortOutS), .ChangeIrq(ChangeIrqS)
  );

  always #10 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doStore(input logic [31:0] a, input logic [31:0] d);
    Address   = a;
    WriteData = d;
    MemWrite  = 1'b1;
    tick();
    MemWrite  = 1'b0;
    Address   = 32'h0;
    WriteData = 32'h0;
  endtask

  task automatic rdChk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    Address = a;
    MemRead = 1'b1;
    #1;
    checkVal(tag, ReadData, exp);
    MemRead = 1'b0;
    Address = 32'h0;
  endtask

  task automatic rdChkS(input string tag, input logic [31:0] a, input logic [31:0] exp);
    Address = a;
    MemRead = 1'b1;
    #1;
    checkVal(tag, ReadDataS, exp);
    MemRead = 1'b0;
    Address = 32'h0;
  endtask

  // Apply a new PortIn value and advance two edges. The change event is then
  // pending and is committed by the next edge (plain tick or a store).
  task automatic primeChange(input logic [7:0] v);
    PortIn = v;
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b0;
    Address   = 32'h0;
    WriteData = 32'h0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    PortIn    = 8'h00;
    tick();
    tick();

    // Reset state, visible through the combinational read path while held
    checkVal("rst_portout", PortOut, 32'h0);
    checkVal("rst_irq", {31'h0, ChangeIrq}, 32'h0);
    rdChk("rst_status", A_ST, 32'h0);
    rdChk("rst_cnt", A_CNT, 32'h0);
    reset = 1'b1;
    tick();

    // 1: PORT_OUT store and load; same-cycle load sees the pre-edge value
    Address   = A_OUT;
    WriteData = 32'hDEADBEEF;
    MemWrite  = 1'b1;
    MemRead   = 1'b1;
    #1;
    checkVal("hit_in_window", {31'h0, Hit}, 32'h1);
    checkVal("rd_pre_edge", ReadData, 32'h0);
    tick();
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    checkVal("portout_store", PortOut, 32'hDEADBEEF);
    rdChk("portout_load", A_OUT, 32'hDEADBEEF);
    rdChk("rd_no_memread", 32'h0, 32'h0);

    // 2: synchronizer latency, first change event
    PortIn = 8'h5A;
    tick();
    rdChk("portin_after_N", A_IN, 32'h0);
    tick();
    rdChk("portin_after_N1", A_IN, 32'h0000005A);
    rdChk("status_after_N1", A_ST, 32'h0);
    tick();
    rdChk("status_after_N2", A_ST, 32'h1);
    checkVal("irq_after_N2", {31'h0, ChangeIrq}, 32'h1);
    rdChk("cnt_after_N2", A_CNT, 32'h1);
    tick();
    rdChk("cnt_steady", A_CNT, 32'h1);

    // 3: overflow and W1C of each bit
    primeChange(8'h5B);
    tick();
    rdChk("status_ovf", A_ST, 32'h3);
    rdChk("cnt_two", A_CNT, 32'h2);
    doStore(A_ST, 32'h1);
    rdChk("w1c_chg", A_ST, 32'h2);
    checkVal("irq_cleared", {31'h0, ChangeIrq}, 32'h0);
    doStore(A_ST, 32'h2);
    rdChk("w1c_ovf", A_ST, 32'h0);

    // 4: set-wins races
    primeChange(8'h22);
    tick();
    rdChk("race_pre_status", A_ST, 32'h1);
    primeChange(8'h33);
    doStore(A_ST, 32'h1);
    rdChk("race_chg_set_wins", A_ST, 32'h1);
    rdChk("race_cnt4", A_CNT, 32'h4);
    primeChange(8'h44);
    doStore(A_CNT, 32'hFFFF_FFFF);
    rdChk("race_cnt_clear", A_CNT, 32'h1);
    rdChk("race_ovf_after_clr", A_ST, 32'h3);
    primeChange(8'h55);
    doStore(A_ST, 32'h2);
    rdChk("race_ovf_set_wins", A_ST, 32'h3);
    rdChk("race_cnt2", A_CNT, 32'h2);

    // 5: saturation on the 4-bit counter
    PortIn = 8'h00;
    tick();
    reset = 1'b0;
    #1;
    reset = 1'b1;
    tick();
    for (int i = 1; i <= 20; i++) begin
      PortIn = (i % 2 == 1) ? 8'h01 : 8'h00;
      tick();
      tick();
      tick();
      if (i == 15) begin
        rdChkS("sat_at_15", A_CNT, 32'hF);
        rdChk("wide_at_15", A_CNT, 32'hF);
      end
      if (i == 16) begin
        rdChkS("sat_no_wrap", A_CNT, 32'hF);
        rdChk("wide_at_16", A_CNT, 32'h10);
      end
    end
    rdChkS("sat_at_20", A_CNT, 32'hF);
    rdChk("wide_at_20", A_CNT, 32'h14);
    doStore(A_CNT, 32'h0);
    rdChkS("sat_cleared", A_CNT, 32'h0);
    rdChk("wide_cleared", A_CNT, 32'h0);

    // 6: out-of-window accesses leave state alone
    doStore(A_OUT, 32'hA5A5A5A5);
    Address   = BASE + 32'h10;
    WriteData = 32'h12345678;
    MemWrite  = 1'b1;
    MemRead   = 1'b1;
    #1;
    checkVal("hit_above", {31'h0, Hit}, 32'h0);
    checkVal("rd_above", ReadData, 32'h0);
    tick();
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    Address  = BASE - 32'h4;
    #1;
    checkVal("hit_below", {31'h0, Hit}, 32'h0);
    doStore(BASE - 32'h4, 32'h0);
    doStore(BASE + 32'h18, 32'h3);
    checkVal("portout_untouched", PortOut, 32'hA5A5A5A5);
    rdChk("status_untouched", A_ST, 32'h3);

    // Mid-run reset with a store pending: state clears at once, store dropped
    PortIn    = 8'h5A;
    Address   = A_OUT;
    WriteData = 32'h11111111;
    MemWrite  = 1'b1;
    #3;
    reset = 1'b0;
    #1;
    checkVal("midrst_portout", PortOut, 32'h0);
    checkVal("midrst_irq", {31'h0, ChangeIrq}, 32'h0);
    tick();
    checkVal("midrst_store_dropped", PortOut, 32'h0);
    MemWrite = 1'b0;
    rdChk("midrst_status", A_ST, 32'h0);
    rdChk("midrst_portin", A_IN, 32'h0);
    rdChk("midrst_cnt", A_CNT, 32'h0);

    // Release with PortIn nonzero: exactly one event
    reset = 1'b1;
    tick();
    tick();
    tick();
    rdChk("release_status", A_ST, 32'h1);
    rdChk("release_cnt", A_CNT, 32'h1);
    tick();
    rdChk("release_cnt_once", A_CNT, 32'h1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
